// File: rtl/wb_uart.sv
// wb_uart: 8-bit Wishbone slave UART giving the MCU a polled serial console.
//
// CPU writes to DATA are queued in a small TX FIFO and serialised onto
// uart_tx (8N1, LSB first). Frames arriving on uart_rx are deserialised into
// a single holding register that the CPU polls through STATUS/DATA.
//
// Register map (adr_i[1:0]):
//   0 DATA    write: push byte to TX FIFO; read: RX holding byte, clears rx_valid
//   1 STATUS  {3'b0, frame_err, overrun, rx_valid, tx_idle, tx_full};
//             a read clears overrun and frame_err
//   2 DIV_LO  baud divisor bits 7:0 (bit period = max(DIV,3)+1 clocks)
//   3 DIV_HI  baud divisor bits 15:8
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   stb_i, we_i        Wishbone strobe and write enable
//   adr_i, dat_i       register select and write data
//   ack_o, dat_o       one-cycle acknowledge and registered read data
//   uart_tx            serial output, idles high
//   uart_rx            serial input, asynchronous, idles high
//
// Bus handshake: a request is stb_i held with stable we_i/adr_i/dat_i. The
// slave answers with ack_o exactly one clock later for one cycle
// (ack_o <= stb_i & ~ack_o). All register side effects happen on the edge
// that raises ack_o; dat_o carries read data in the ack cycle and is 0 at
// every other time. A strobe held continuously is acknowledged on alternate
// cycles, each ack completing a separate transfer.
//
// Debug visibility: tx_state and rx_state are uart_state_t registers with
// stable names so checkers can bind to them directly.
module wb_uart #(
    parameter int WB_DATA_WIDTH = 8,
    parameter int WB_ADDR_WIDTH = 2,
    parameter int TX_FIFO_DEPTH = 4,
    parameter int DEFAULT_DIV   = 103
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [WB_ADDR_WIDTH-1:0] adr_i,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    output logic                     ack_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    output logic                     uart_tx,
    input  logic                     uart_rx
);

    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       bus_cyc;
    logic       bus_wr;
    logic       bus_rd;
    logic [1:0] reg_sel;

    assign bus_cyc = stb_i & ~ack_o;
    assign bus_wr  = bus_cyc & we_i;
    assign bus_rd  = bus_cyc & ~we_i;
    assign reg_sel = adr_i[1:0];

    logic wr_data;
    logic wr_div_lo;
    logic wr_div_hi;
    logic rd_data;
    logic rd_status;

    assign wr_data   = bus_wr && (reg_sel == 2'd0);
    assign wr_div_lo = bus_wr && (reg_sel == 2'd2);
    assign wr_div_hi = bus_wr && (reg_sel == 2'd3);
    assign rd_data   = bus_rd && (reg_sel == 2'd0);
    assign rd_status = bus_rd && (reg_sel == 2'd1);

    // ------------------------------------------------------------------
    // State shared between the bus and the serial engines
    // ------------------------------------------------------------------
    logic [15:0]      div_reg;
    logic [15:0]      eff_div;
    logic [15:0]      half_div_m1;

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             overrun;
    logic             frame_err;

    uart_state_t      tx_state;
    uart_state_t      rx_state;

    logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             tx_pop;
    logic             tx_full;
    logic             tx_idle;

    logic [15:0]      tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;

    logic             rx_s1;
    logic             rx_s2;
    logic             rx_d;
    logic [15:0]      rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;

    // Divisors below 3 leave too few clocks per bit for mid-bit sampling.
    assign eff_div = (div_reg < 16'd3) ? 16'd3 : div_reg;

    // (eff_div+1)/2 - 1 without needing a 17-bit intermediate.
    assign half_div_m1 = (eff_div >> 1) + {15'd0, eff_div[0]} - 16'd1;

    assign tx_full = (fifo_count == CNT_W'(TX_FIFO_DEPTH));
    assign tx_idle = (fifo_count == '0) && (tx_state == ST_IDLE);

    // The TX engine takes the next byte either from IDLE or at the end of a
    // stop bit, which is what makes consecutive frames gap-free.
    assign tx_pop = (fifo_count != '0) &&
                    ((tx_state == ST_IDLE) ||
                     ((tx_state == ST_STOP) && (tx_cnt == 16'd0)));

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign fifo_push = wr_data && (!tx_full || tx_pop);

    // ------------------------------------------------------------------
    // Bus registers: ack, read data, divisor
    // ------------------------------------------------------------------
    logic [7:0] rd_mux;

    always_comb begin
        rd_mux = 8'h00;
        case (reg_sel)
            2'd0: rd_mux = rx_data;
            2'd1: rd_mux = {3'b000, frame_err, overrun, rx_valid, tx_idle, tx_full};
            2'd2: rd_mux = div_reg[7:0];
            2'd3: rd_mux = div_reg[15:8];
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o   <= 1'b0;
            dat_o   <= '0;
            div_reg <= 16'(DEFAULT_DIV);
        end else begin
            ack_o <= bus_cyc;
            dat_o <= bus_rd ? rd_mux : '0;
            if (wr_div_lo) div_reg[7:0]  <= dat_i;
            if (wr_div_hi) div_reg[15:8] <= dat_i;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO (circular buffer)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (fifo_push) fifo_mem[wr_ptr] <= dat_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, tx_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM. The bit counter is reloaded from eff_div at every bit
    // boundary, so a divisor write only changes timing from the next bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    uart_tx <= 1'b1;
                    if (tx_pop) begin
                        tx_shift <= fifo_mem[rd_ptr];
                        tx_cnt   <= eff_div;
                        uart_tx  <= 1'b0;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt   <= eff_div;
                        tx_bit   <= 3'd0;
                        uart_tx  <= tx_shift[0];
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= eff_div;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            uart_tx  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == 16'd0) begin
                        if (tx_pop) begin
                            tx_shift <= fifo_mem[rd_ptr];
                            tx_cnt   <= eff_div;
                            uart_tx  <= 1'b0;
                            tx_state <= ST_START;
                        end else begin
                            uart_tx  <= 1'b1;
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: begin
                    uart_tx  <= 1'b1;
                    tx_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser plus one extra delay stage for falling-edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM and holding register. Bus-side clears are written first so
    // that a receive event in the same cycle overrides them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state  <= ST_IDLE;
            rx_cnt    <= 16'd0;
            rx_bit    <= 3'd0;
            rx_shift  <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rd_data) rx_valid <= 1'b0;
            if (rd_status) begin
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end

            case (rx_state)
                ST_IDLE: begin
                    if (rx_d && !rx_s2) begin
                        rx_cnt   <= half_div_m1;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (!rx_s2) begin
                            rx_cnt   <= eff_div;
                            rx_bit   <= 3'd0;
                            rx_state <= ST_DATA;
                        end else begin
                            // Line back high at mid start bit: a glitch.
                            rx_state <= ST_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= eff_div;
                        if (rx_bit == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == 16'd0) begin
                        rx_state <= ST_IDLE;
                        if (!rx_s2) begin
                            frame_err <= 1'b1;
                        end else if (!rx_valid || rd_data) begin
                            // A DATA read this cycle returns the old byte
                            // and frees the register for the new one.
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Testbench for wb_uart: directed bus transfers and serial frames. Expected
// read data is queued when each transfer is issued and checked by a bus
// monitor on ack; expected TX bytes are queued when written and checked by a
// serial monitor that decodes uart_tx at 4 clocks per bit.
module tb_wb_uart;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       stb_i;
    logic       we_i;
    logic [1:0] adr_i;
    logic [7:0] dat_i;
    logic       ack_o;
    logic [7:0] dat_o;
    logic       uart_tx;
    logic       uart_rx;

    wb_uart #(
        .WB_DATA_WIDTH(8),
        .WB_ADDR_WIDTH(2),
        .TX_FIFO_DEPTH(4),
        .DEFAULT_DIV  (103)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .ack_o  (ack_o),
        .dat_o  (dat_o),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge clk_i);
        cyc = cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_q[$];
    string      name_q[$];
    logic [7:0] tx_exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [7:0] d,
                           input logic [7:0] e, input string nm);
        int waited = 0;
        if (ack_o === 1'b1) begin
            @(posedge clk_i);
            #1;
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
        stb_i = 1'b1;
        we_i  = we;
        adr_i = a;
        dat_i = d;
        do begin
            @(posedge clk_i);
            #1;
            waited++;
        end while (ack_o !== 1'b1 && waited < 8);
        check({"ack_lat_", nm}, waited, 1);
        if (ack_o !== 1'b1) begin
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic wb_rd(input logic [1:0] a, input logic [7:0] e, input string nm);
        wb_xfer(1'b0, a, 8'h00, e, nm);
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [7:0] d);
        wb_xfer(1'b1, a, d, 8'h00, "wr_dat_zero");
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One 8N1 frame at 4 clocks per bit; stop_b chooses the stop level.
    task automatic send_rx(input logic [7:0] b, input logic stop_b);
        uart_rx = 1'b0;
        wait_cycles(4);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cycles(4);
        end
        uart_rx = stop_b;
        wait_cycles(4);
        uart_rx = 1'b1;
        wait_cycles(4);
    endtask

    // ---------------- bus monitor / scoreboard ----------------
    initial forever begin
        @(negedge clk_i);
        if (ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_unexpected_ack: got dat_o 0x%0h expected no ack", dat_o);
            end else begin
                logic [7:0] e;
                string      nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({"bus_", nm}, dat_o, e);
            end
        end
    end

    // ---------------- serial TX monitor (4 clocks per bit) ----------------
    int          tx_idx    = 0;
    logic [39:0] tx_smp;
    bit          b2b_en    = 1'b0;
    bit          have_prev = 1'b0;
    int          prev_start = 0;

    initial forever begin
        @(negedge clk_i);
        if (rst_i === 1'b1) begin
            tx_idx = 0;
        end else if (tx_idx == 0) begin
            if (uart_tx === 1'b0) begin
                tx_smp[0] = 1'b0;
                tx_idx    = 1;
                if (b2b_en && have_prev) check("tx_b2b_gap", cyc - prev_start, 40);
                have_prev  = 1'b1;
                prev_start = cyc;
            end
        end else begin
            tx_smp[tx_idx] = uart_tx;
            tx_idx++;
            if (tx_idx == 40) begin
                logic       ok;
                logic [7:0] got;
                ok  = 1'b1;
                got = 8'h00;
                for (int i = 0; i < 4; i++)   if (tx_smp[i] !== 1'b0) ok = 1'b0;
                for (int i = 36; i < 40; i++) if (tx_smp[i] !== 1'b1) ok = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    got[b] = tx_smp[4 + 4 * b];
                    for (int k = 1; k < 4; k++)
                        if (tx_smp[4 + 4 * b + k] !== got[b]) ok = 1'b0;
                end
                check("tx_frame_shape", ok, 1);
                if (tx_exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected_frame: got 0x%0h expected no frame", got);
                end else begin
                    check("tx_byte", got, tx_exp_q.pop_front());
                end
                tx_idx = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lows;
        rst_i   = 1'b1;
        stb_i   = 1'b0;
        we_i    = 1'b0;
        adr_i   = 2'd0;
        dat_i   = 8'h00;
        uart_rx = 1'b1;

        // Reset values
        wait_cycles(5);
        check("rst_ack", ack_o, 0);
        check("rst_dat", dat_o, 8'h00);
        check("rst_tx", uart_tx, 1);
        rst_i = 1'b0;
        wait_cycles(1);
        wb_rd(2'd1, 8'h02, "status_reset");
        wb_rd(2'd2, 8'h67, "div_lo_reset");
        wb_rd(2'd3, 8'h00, "div_hi_reset");

        // Single TX at DIV=3
        wb_wr(2'd2, 8'h03);
        wb_rd(2'd2, 8'h03, "div_lo_rb");
        tx_exp_q.push_back(8'hA5);
        wb_wr(2'd0, 8'hA5);
        wait_cycles(60);
        check("tx_q_drained_single", tx_exp_q.size(), 0);
        wb_rd(2'd1, 8'h02, "status_after_tx");

        // FIFO overflow while busy; 0x06 must be dropped
        b2b_en    = 1'b1;
        have_prev = 1'b0;
        for (int i = 1; i <= 5; i++) tx_exp_q.push_back(8'(i));
        for (int i = 1; i <= 5; i++) wb_wr(2'd0, 8'(i));
        wb_rd(2'd1, 8'h01, "status_tx_full");
        wb_wr(2'd0, 8'h06);
        wb_rd(2'd1, 8'h01, "status_still_full");
        wait_cycles(220);
        check("tx_q_drained_ovf", tx_exp_q.size(), 0);
        b2b_en = 1'b0;
        wb_rd(2'd1, 8'h02, "status_after_ovf");

        // RX at DIV=3
        send_rx(8'h3C, 1'b1);
        wb_rd(2'd1, 8'h06, "status_rx_valid");
        wb_rd(2'd0, 8'h3C, "rx_data_3c");
        wb_rd(2'd1, 8'h02, "status_rx_cleared");

        // Short low glitch must not start a byte
        uart_rx = 1'b0;
        wait_cycles(2);
        uart_rx = 1'b1;
        wait_cycles(30);
        wb_rd(2'd1, 8'h02, "status_after_glitch");

        // Overrun: second byte dropped, first kept
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        wb_rd(2'd0, 8'h11, "rx_data_overrun");
        wb_rd(2'd1, 8'h0A, "status_overrun");
        wb_rd(2'd1, 8'h02, "status_overrun_clr");

        // Framing error: stop bit low
        send_rx(8'h33, 1'b0);
        wb_rd(2'd1, 8'h12, "status_frame_err");
        wb_rd(2'd1, 8'h02, "status_frame_clr");

        // Reset during data bit 3 of an all-zero byte
        wb_wr(2'd2, 8'h03);
        wb_wr(2'd0, 8'h00);
        wait_cycles(18);
        check("tx_low_before_rst", uart_tx, 0);
        rst_i = 1'b1;
        wait_cycles(1);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_tx_next", uart_tx, 1);
        wait_cycles(1);
        wb_rd(2'd1, 8'h02, "status_after_rst");
        wb_rd(2'd2, 8'h67, "div_lo_after_rst");
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (uart_tx !== 1'b1) lows++;
        end
        check("no_tx_after_rst", lows, 0);

        wait_cycles(5);
        check("bus_q_drained", exp_q.size(), 0);
        check("tx_q_drained_end", tx_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_uart.md
Name: wb_uart

Overview:
- 8-bit Wishbone slave UART that gives the 6502 MCU a serial console.
- Sits on wb_bus next to wb_ram and wb_gpio, with a 4-byte address window.
- Serialises CPU writes from a TX FIFO onto uart_tx.
- Deserialises uart_rx into a single RX holding register that the CPU polls.

Parameters:
- WB_DATA_WIDTH, 8, bus data width; only 8 is supported.
- WB_ADDR_WIDTH, 2, decoded address bits; higher bits of adr_i are ignored.
- TX_FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, at least 2.
- DEFAULT_DIV, 103, reset value of the baud divisor; bit period = DIV+1 clocks.

Ports:
- clk_i, input, 1, system clock.
- rst_i, input, 1, synchronous active-high reset.
- stb_i, input, 1, Wishbone strobe (cycle request).
- we_i, input, 1, write enable.
- adr_i, input, WB_ADDR_WIDTH, register select.
- dat_i, input, WB_DATA_WIDTH, write data.
- ack_o, output, 1, Wishbone acknowledge.
- dat_o, output, WB_DATA_WIDTH, read data.
- uart_tx, output, 1, serial out; idles high.
- uart_rx, input, 1, serial in; asynchronous, idles high.

Behaviour:
- One clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset values:
  - ack_o=0, dat_o=0, uart_tx=1.
  - TX FIFO empty; TX and RX FSMs in IDLE.
  - rx_valid=0, overrun=0, frame_err=0, DIV=DEFAULT_DIV.
- A reset mid-frame aborts immediately; uart_tx goes to 1 on the next edge.
- Bus handshake:
  - ack_o <= stb_i & ~ack_o, so ack is one clock after stb_i and lasts one cycle.
  - A held stb_i produces ack on alternate cycles.
  - dat_o is registered and valid in the ack cycle; dat_o=0 when ack_o=0.
  - Register side effects occur only in the cycle that ack_o is set (stb_i & ~ack_o).
- Register map:
  - 0 DATA:
    - Write pushes dat_i to the TX FIFO.
    - Read returns the RX holding byte and clears rx_valid.
  - 1 STATUS (read-only):
    - bit0 tx_full; bit1 tx_idle (FIFO empty and TX FSM IDLE); bit2 rx_valid; bit3 overrun; bit4 frame_err; bits 7:5 = 0.
    - A read clears overrun and frame_err after returning them.
  - 2 DIV_LO, 3 DIV_HI: read/write 16-bit divisor.
  - Effective divisor = max(DIV,3).
  - A divisor change takes effect at the next bit boundary.
- TX FIFO:
  - Circular buffer with read/write pointers and a count.
  - A write is accepted when count<DEPTH, or when the TX FSM pops in the same cycle.
  - Otherwise the write is silently dropped, with no flag.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: pop when the FIFO is non-empty.
  - START drives 0; DATA drives 8 bits LSB first; STOP drives 1.
  - Each state holds for DIV+1 clocks.
  - From STOP, go to START directly if the FIFO is non-empty, giving back-to-back frames with no idle gap.
- RX path:
  - 2-flop synchroniser on uart_rx.
  - IDLE: a falling edge on the synchronised line starts reception.
  - START: wait (DIV+1)/2 clocks, then resample; if the line is high, treat it as a glitch and return to IDLE.
  - DATA: sample at mid-bit every DIV+1 clocks, 8 bits, LSB first.
  - STOP: sample at mid-bit.
    - Low: set frame_err and discard the byte.
    - High and rx_valid=0: load the holding register and set rx_valid.
    - High and rx_valid=1: drop the new byte and set overrun.
- Simultaneous events:
  - A CPU DATA read in the same cycle a new byte completes returns the old byte.
  - In that case the new byte loads, rx_valid stays 1, and overrun is not set.
  - A STATUS read in the same cycle a flag sets: the new event wins and the flag remains 1.

Test Plan:
- Reset values: assert rst_i for 5 cycles, then read STATUS and DIV -> STATUS=0x02, DIV_LO=0x67, DIV_HI=0x00, uart_tx=1, ack one cycle after stb.
- Single TX at DIV=3:
  - Write DIV_LO=3, then DATA=0xA5.
  - uart_tx shows a 0 start bit, then 1,0,1,0,0,1,0,1, then a 1 stop bit, each bit exactly 4 clocks.
  - STATUS reads 0x02 afterwards.
- TX FIFO overflow while busy:
  - Write 0x01..0x06 back-to-back (DEPTH=4, first byte already popped).
  - 0x01..0x05 are transmitted; 0x06 is dropped.
  - tx_full=1 is seen after the 5th write; no gaps between frames.
- RX at DIV=3:
  - Drive frame 0x3C on uart_rx at 4 clocks/bit -> STATUS bit2=1; DATA read = 0x3C; then STATUS bit2=0.
  - Drive a 2-clock low glitch -> no byte, no flags.
- RX overrun and framing error:
  - Send 0x11 then 0x22 without reading -> DATA=0x11, STATUS bit3=1, and a second STATUS read shows bit3=0.
  - Send 0x33 with the stop bit low -> bit4=1, rx_valid unchanged.
- Mid-operation reset: assert rst_i during TX data bit 3 -> uart_tx=1 the next cycle, FIFO empty, STATUS=0x02, and no further TX activity.
